// File: rtl/gps_clk_ratio_mon.sv
// rtl/gps_clk_ratio_mon.sv - GPS fast/slow clock ratio monitor with slow-clock enable and lock/fault status
module gps_clk_ratio_mon #(
    parameter int DIV_RATIO   = 10,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT_CYC = 32,
    parameter int CNT_W       = 8
) (
    input  logic             gps_clk_fast,
    input  logic             gps_rst,
    input  logic             gps_clk_slow,
    input  logic             clr_fault,
    output logic             slow_ce,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period_last,
    output logic [7:0]       err_cnt
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

    localparam int               GC_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W:0]   GOOD_MIN = (CNT_W+1)'(DIV_RATIO - TOL);
    localparam logic [CNT_W:0]   GOOD_MAX = (CNT_W+1)'(DIV_RATIO + TOL);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic              s1, s2, s3;
    logic [CNT_W-1:0]  per_cnt;
    logic [GC_W-1:0]   good_cnt;
    logic [CNT_W:0]    cand;
    logic              rise, good, timeout, err_evt;

    assign rise    = s2 & ~s3;
    assign cand    = {1'b0, per_cnt} + (CNT_W+1)'(1);
    assign good    = (cand >= GOOD_MIN) && (cand <= GOOD_MAX);
    assign timeout = !rise && (per_cnt == TO_LAST);
    assign err_evt = ((state == ACQ) || (state == LOCKED)) && ((rise && !good) || timeout);

    // Slow clock is plain data here: two flops for metastability, third for edge detect.
    always_ff @(posedge gps_clk_fast or posedge gps_rst) begin
        if (gps_rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            slow_ce     <= 1'b0;
            per_cnt     <= '0;
            period_last <= '0;
        end else begin
            s1      <= gps_clk_slow;
            s2      <= s1;
            s3      <= s2;
            slow_ce <= rise;
            if (rise) begin
                per_cnt     <= '0;
                period_last <= cand[CNT_W] ? '1 : cand[CNT_W-1:0];
            end else if (timeout) begin
                per_cnt <= '0;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
        end
    end

    // locked/fault are written alongside the state so they track it with no extra cycle.
    always_ff @(posedge gps_clk_fast or posedge gps_rst) begin
        if (gps_rst) begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (rise && good) begin
                        good_cnt <= good_cnt + GC_W'(1);
                        if (good_cnt == GC_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (rise) begin
                        good_cnt <= '0;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    if ((rise && !good) || timeout) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

    // A clear in the same cycle as an error event discards the event.
    always_ff @(posedge gps_clk_fast or posedge gps_rst) begin
        if (gps_rst) begin
            err_cnt <= '0;
        end else if (clr_fault) begin
            err_cnt <= '0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
